// File: rtl/charge_scheduler.sv
// -----------------------------------------------------------------------------
// charge_scheduler
//
// Purpose:
//   Arbitrates one shared charger and one shared payment unit between two
//   charging sockets. A requesting socket is granted the charger and the
//   payment unit is enabled. A valid payment converts credit units into
//   charge seconds. The seconds then count down on the 1 s tick until the
//   session completes. The session is dropped if the owning socket withdraws
//   its request. The grant is also released if payment does not arrive
//   within PAY_TIMEOUT ticks.
//
// Parameters:
//   SEC_PER_UNIT : charge seconds granted per credit unit
//   PAY_TIMEOUT  : ticks allowed while waiting for payment
//
// Ports:
//   clk      in   system clock, all logic on the rising edge
//   reset    in   synchronous active-high reset
//   tick     in   one-cycle pulse, 1 s timebase
//   req[1:0] in   level request per socket (bit0 = socket 0)
//   paid     in   one-cycle pulse, payment confirmed
//   amount   in   credit units accompanying paid (valid 1..20)
//   grant    out  one-hot or zero, socket owning the charger
//   pay_en   out  payment unit enable (only while waiting for payment)
//   charging out  charger power enable
//   remain   out  seconds of charge left
//   done     out  one-cycle pulse, session completed normally
// -----------------------------------------------------------------------------
module charge_scheduler #(
  parameter int SEC_PER_UNIT = 6,
  parameter int PAY_TIMEOUT  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] req,
  input  logic       paid,
  input  logic [4:0] amount,
  output logic [1:0] grant,
  output logic       pay_en,
  output logic       charging,
  output logic [7:0] remain,
  output logic       done
);

  // The timeout counter only needs to hold 0..PAY_TIMEOUT-1.
  localparam int            TW         = (PAY_TIMEOUT > 1) ? $clog2(PAY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST    = TW'(PAY_TIMEOUT - 1);
  localparam logic [7:0]    SEC_U8     = 8'(SEC_PER_UNIT);
  localparam logic [4:0]    AMOUNT_MAX = 5'd20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PAY = 2'd1,
    ST_CHARGE   = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t         r_state;
  logic [1:0]     r_grant;
  logic           r_pay_en;
  logic           r_charging;
  logic [7:0]     r_remain;
  logic           r_done;
  logic [TW-1:0]  r_tcnt;
  // 1 = socket 1 was served last, so socket 0 wins a tie next time.
  logic           r_last1;

  logic [1:0]     w_hold;
  logic           w_owner_req;
  logic           w_amount_ok;
  logic [7:0]     w_load;
  logic           w_pick1;
  logic [1:0]     w_pick;
  logic           w_served1;

  // Per-socket: is the granted socket still asserting its request?
  // The non-granted bit is masked out, so it cannot disturb a session.
  for (genvar gi = 0; gi < 2; gi++) begin : g_hold
    assign w_hold[gi] = r_grant[gi] & req[gi];
  end

  assign w_owner_req = |w_hold;
  assign w_amount_ok = (amount != 5'd0) && (amount <= AMOUNT_MAX);
  // 20 units * 6 s = 120 fits in 8 bits with the default parameters.
  assign w_load      = {3'b000, amount} * SEC_U8;

  // Round-robin pick: socket 1 wins only if it asks alone, or if both ask
  // and socket 0 was the one served last.
  assign w_pick1     = req[1] & (~req[0] | ~r_last1);
  assign w_pick      = {w_pick1, req[0] & ~w_pick1};
  assign w_served1   = r_grant[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= 2'b00;
      r_pay_en   <= 1'b0;
      r_charging <= 1'b0;
      r_remain   <= 8'd0;
      r_done     <= 1'b0;
      r_tcnt     <= '0;
      r_last1    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (req != 2'b00) begin
            r_state  <= ST_WAIT_PAY;
            r_grant  <= w_pick;
            r_pay_en <= 1'b1;
            r_tcnt   <= '0;
          end
        end

        ST_WAIT_PAY: begin
          if (!w_owner_req) begin
            // Owner walked away: abort wins over paid and tick.
            r_state  <= ST_IDLE;
            r_grant  <= 2'b00;
            r_pay_en <= 1'b0;
            r_remain <= 8'd0;
            r_tcnt   <= '0;
            r_last1  <= w_served1;
          end else if (paid && w_amount_ok) begin
            // A valid payment beats a timeout tick in the same cycle.
            r_state    <= ST_CHARGE;
            r_pay_en   <= 1'b0;
            r_charging <= 1'b1;
            r_remain   <= w_load;
            r_tcnt     <= '0;
            r_last1    <= w_served1;
          end else if (tick) begin
            if (r_tcnt == TO_LAST) begin
              r_state  <= ST_IDLE;
              r_grant  <= 2'b00;
              r_pay_en <= 1'b0;
              r_tcnt   <= '0;
              r_last1  <= w_served1;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
            end
          end
        end

        ST_CHARGE: begin
          if (!w_owner_req) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'b00;
            r_charging <= 1'b0;
            r_remain   <= 8'd0;
            r_last1    <= w_served1;
          end else if (tick) begin
            // remain is never 0 here in normal operation; treating 0 like 1
            // keeps a corrupted count from wrapping to 255.
            if (r_remain <= 8'd1) begin
              r_state    <= ST_DONE;
              r_grant    <= 2'b00;
              r_charging <= 1'b0;
              r_remain   <= 8'd0;
              r_done     <= 1'b1;
              r_last1    <= w_served1;
            end else begin
              r_remain <= r_remain - 8'd1;
            end
          end
        end

        ST_DONE: begin
          // Single-cycle completion pulse. Any pending request is looked at
          // only once IDLE has been entered.
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state    <= ST_IDLE;
          r_grant    <= 2'b00;
          r_pay_en   <= 1'b0;
          r_charging <= 1'b0;
          r_remain   <= 8'd0;
          r_done     <= 1'b0;
          r_tcnt     <= '0;
        end
      endcase
    end
  end

  assign grant    = r_grant;
  assign pay_en   = r_pay_en;
  assign charging = r_charging;
  assign remain   = r_remain;
  assign done     = r_done;

endmodule

// File: tb/tb_charge_scheduler.sv
// -----------------------------------------------------------------------------
// tb_charge_scheduler
//
// Purpose:
//   Self-checking bench for charge_scheduler. It runs directed scenarios for
//   each feature and then a randomized run. The randomized run is compared
//   cycle by cycle against a session-level reference model. That model tracks
//   the owner socket, the payment phase, the seconds left and the pending
//   completion pulse.
// -----------------------------------------------------------------------------
module tb_charge_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] req;
  logic       paid;
  logic [4:0] amount;
  logic [1:0] grant;
  logic       pay_en;
  logic       charging;
  logic [7:0] remain;
  logic       done;

  int total = 0;
  int bad   = 0;

  charge_scheduler #(.SEC_PER_UNIT(6), .PAY_TIMEOUT(30)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .req      (req),
    .paid     (paid),
    .amount   (amount),
    .grant    (grant),
    .pay_en   (pay_en),
    .charging (charging),
    .remain   (remain),
    .done     (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_owner;      // -1 = nobody holds the charger, else socket number
  bit m_paying;     // owner still has to pay
  bit m_charging;
  bit m_just_done;  // completion pulse pending this cycle
  int m_secs;
  int m_waited;     // ticks seen while waiting for payment
  int m_last;       // socket served most recently

  task automatic model_update();
    if (reset) begin
      m_owner = -1; m_paying = 0; m_charging = 0; m_just_done = 0;
      m_secs = 0; m_waited = 0; m_last = 1;
    end else if (m_just_done) begin
      m_just_done = 0;
    end else if (m_owner < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) m_owner = 1 - m_last;
        else              m_owner = req[1] ? 1 : 0;
        m_paying = 1;
        m_waited = 0;
      end
    end else if (!req[m_owner]) begin
      m_last = m_owner; m_owner = -1; m_paying = 0; m_charging = 0; m_secs = 0;
    end else if (m_paying) begin
      if (paid && amount >= 1 && amount <= 20) begin
        m_secs = int'(amount) * 6; m_paying = 0; m_charging = 1; m_last = m_owner;
      end else if (tick) begin
        m_waited++;
        if (m_waited == 30) begin
          m_last = m_owner; m_owner = -1; m_paying = 0;
        end
      end
    end else if (m_charging && tick) begin
      if (m_secs == 1) begin
        m_secs = 0; m_charging = 0; m_last = m_owner; m_owner = -1; m_just_done = 1;
      end else begin
        m_secs--;
      end
    end
  endtask

  function automatic logic [12:0] exp_vec();
    logic [1:0] g;
    g = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    return {g, m_paying, m_charging, 8'(m_secs), m_just_done};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {grant, pay_en, charging, remain, done};
  endfunction

  // One clock: the model sees the same inputs the DUT samples, outputs are
  // stable #1 later, and single-cycle pulses are cleared for the next cycle.
  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    tick = 1'b0;
    paid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00; tick = 1'b0; paid = 1'b0; amount = 5'd0;
    cyc();
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    tick = 1'b1; req = 2'b11; paid = 1'b1; amount = 5'd5; reset = 1'b1;
    cyc();
    reset = 1'b0; req = 2'b00;
    total++; if (grant !== 2'b00)  begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
    total++; if (pay_en !== 1'b0)  begin bad++; $display("FAIL reset_pay_en: got %b want 0", pay_en); end
    total++; if (charging !== 1'b0) begin bad++; $display("FAIL reset_charging: got %b want 0", charging); end
    total++; if (remain !== 8'd0)  begin bad++; $display("FAIL reset_remain: got %0d want 0", remain); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    $display("test_reset: outputs cleared");
  endtask

  task automatic test_basic_session();
    int dones;
    do_reset();
    req = 2'b01;
    cyc();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL basic_grant: got %b want 01", grant); end
    total++; if (pay_en !== 1'b1) begin bad++; $display("FAIL basic_pay_en: got %b want 1", pay_en); end
    paid = 1'b1; amount = 5'd5;
    cyc();
    total++; if (charging !== 1'b1) begin bad++; $display("FAIL basic_charging: got %b want 1", charging); end
    total++; if (remain !== 8'd30)  begin bad++; $display("FAIL basic_remain: got %0d want 30", remain); end
    total++; if (pay_en !== 1'b0)   begin bad++; $display("FAIL basic_pay_en_off: got %b want 0", pay_en); end
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      tick = 1'b1;
      cyc();
      if (done === 1'b1) dones++;
      if (i < 29) begin
        cyc();
        if (done === 1'b1) dones++;
      end
    end
    total++; if (dones !== 1)       begin bad++; $display("FAIL basic_done_count: got %0d want 1", dones); end
    total++; if (done !== 1'b1 || grant !== 2'b00)
      begin bad++; $display("FAIL basic_done_cycle: got done=%b grant=%b want done=1 grant=00", done, grant); end
    cyc();
    total++; if (done !== 1'b0 || grant !== 2'b00 || remain !== 8'd0)
      begin bad++; $display("FAIL basic_after_done: got done=%b grant=%b remain=%0d want 0/00/0", done, grant, remain); end
    total++; if (dut_vec() !== exp_vec())
      begin bad++; $display("FAIL basic_model: got %h want %h", dut_vec(), exp_vec()); end
    req = 2'b00;
    cyc();
    $display("test_basic_session: 5 units, 30 s, done pulses=%0d", dones);
  endtask

  task automatic test_round_robin();
    logic [1:0] first;
    do_reset();
    req = 2'b11;
    cyc();
    first = grant;
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL rr_first: got %b want 01", grant); end
    paid = 1'b1; amount = 5'd1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      tick = 1'b1;
      cyc();
    end
    cyc();   // DONE -> IDLE
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL rr_idle_gap: got %b want 00", grant); end
    cyc();
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL rr_second: got %b want 10", grant); end
    total++; if (dut_vec() !== exp_vec())
      begin bad++; $display("FAIL rr_model: got %h want %h", dut_vec(), exp_vec()); end
    req = 2'b00;
    cyc();
    $display("test_round_robin: first=%b second=%b", first, 2'b10);
  endtask

  task automatic test_timeout();
    do_reset();
    req = 2'b10;
    cyc();
    for (int i = 0; i < 29; i++) begin
      tick = 1'b1;
      cyc();
    end
    total++; if (pay_en !== 1'b1 || grant !== 2'b10)
      begin bad++; $display("FAIL to_early: got pay_en=%b grant=%b want 1/10", pay_en, grant); end
    tick = 1'b1;
    cyc();
    total++; if (grant !== 2'b00 || pay_en !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL to_expire: got grant=%b pay_en=%b done=%b want 00/0/0", grant, pay_en, done); end
    cyc();   // request still held: regranted
    for (int i = 0; i < 29; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b1; paid = 1'b1; amount = 5'd2;
    cyc();
    total++; if (charging !== 1'b1 || remain !== 8'd12)
      begin bad++; $display("FAIL to_paid_wins: got charging=%b remain=%0d want 1/12", charging, remain); end
    req = 2'b00;
    cyc();
    $display("test_timeout: grant released after 30 ticks, paid beats timeout");
  endtask

  task automatic test_abort();
    do_reset();
    req = 2'b01;
    cyc();
    paid = 1'b1; amount = 5'd7;
    cyc();
    tick = 1'b1; cyc();
    tick = 1'b1; cyc();
    total++; if (remain !== 8'd40) begin bad++; $display("FAIL abort_remain40: got %0d want 40", remain); end
    req = 2'b10; tick = 1'b1;   // owner drops, other socket appears
    cyc();
    total++; if (remain !== 8'd0 || charging !== 1'b0 || grant !== 2'b00 || done !== 1'b0)
      begin bad++; $display("FAIL abort_state: got remain=%0d charging=%b grant=%b done=%b want 0/0/00/0",
                            remain, charging, grant, done); end
    cyc();
    total++; if (done !== 1'b0 || grant !== 2'b10)
      begin bad++; $display("FAIL abort_next: got done=%b grant=%b want 0/10", done, grant); end
    req = 2'b00;
    cyc();
    $display("test_abort: session dropped at 40 s");
  endtask

  task automatic test_bad_amount();
    do_reset();
    req = 2'b01;
    cyc();
    paid = 1'b1; amount = 5'd0;
    cyc();
    total++; if (pay_en !== 1'b1 || charging !== 1'b0)
      begin bad++; $display("FAIL amt0: got pay_en=%b charging=%b want 1/0", pay_en, charging); end
    paid = 1'b1; amount = 5'd21;
    cyc();
    total++; if (pay_en !== 1'b1 || charging !== 1'b0)
      begin bad++; $display("FAIL amt21: got pay_en=%b charging=%b want 1/0", pay_en, charging); end
    paid = 1'b1; amount = 5'd20;
    cyc();
    total++; if (remain !== 8'd120 || charging !== 1'b1)
      begin bad++; $display("FAIL amt20: got remain=%0d charging=%b want 120/1", remain, charging); end
    req = 2'b00;
    cyc();
    paid = 1'b1; amount = 5'd5;   // no owner: must be ignored
    cyc();
    total++; if (charging !== 1'b0 || pay_en !== 1'b0 || grant !== 2'b00)
      begin bad++; $display("FAIL paid_idle: got charging=%b pay_en=%b grant=%b want 0/0/00", charging, pay_en, grant); end
    $display("test_bad_amount: 0 and 21 ignored, 20 -> 120 s");
  endtask

  task automatic test_reset_mid_charge();
    do_reset();
    req = 2'b01;
    cyc();
    paid = 1'b1; amount = 5'd3;
    cyc();
    tick = 1'b1; cyc();
    reset = 1'b1; tick = 1'b1;
    cyc();
    total++; if (dut_vec() !== 13'd0)
      begin bad++; $display("FAIL rst_mid_charge: got %h want 0", dut_vec()); end
    reset = 1'b0; req = 2'b11;
    cyc();
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL rst_pointer: got %b want 01", grant); end
    req = 2'b00;
    cyc();
    $display("test_reset_mid_charge: outputs cleared, pointer restored");
  endtask

  task automatic test_random();
    int sessions;
    int errs;
    sessions = 0;
    errs = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 29) == 0) req = 2'($urandom_range(0, 3));
      tick = ($urandom_range(0, 2) == 0);
      paid = ($urandom_range(0, 5) == 0);
      amount = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 4));
      cyc();
      if (done === 1'b1) sessions++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        errs++;
        if (errs <= 10) $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    reset = 1'b0;
    $display("test_random: 4000 cycles, %0d completed sessions", sessions);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; req = 2'b00; paid = 1'b0; amount = 5'd0;
    m_owner = -1; m_paying = 0; m_charging = 0; m_just_done = 0;
    m_secs = 0; m_waited = 0; m_last = 1;
    test_reset();
    test_basic_session();
    test_round_robin();
    test_timeout();
    test_abort();
    test_bad_amount();
    test_reset_mid_charge();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
